// File: rtl/stage_ex.sv
// Execute stage: ALU, iterative shift-add multiplier and EX/MEM register.
// MUL holds IF/ID/IDEX for 33 cycles while bubbles drain into MEM.
module stage_ex (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] a_ex,
  input  logic [31:0] b_ex,
  input  logic [31:0] imm_ex,
  input  logic [31:0] pc_ex,
  input  logic [4:0]  rw_ex,
  input  logic [3:0]  op_ex,
  input  logic        wreg_ex,
  input  logic        wmem_ex,
  input  logic        rmem_ex,
  input  logic        aluimm_ex,
  input  logic        shift_ex,
  input  logic        jal_ex,
  output logic        stall_ex,
  output logic [31:0] alu_mem,
  output logic [31:0] b_mem,
  output logic [4:0]  rw_mem,
  output logic        wreg_mem,
  output logic        wmem_mem,
  output logic        rmem_mem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_LUI  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;

  logic [31:0] alu_q, alu_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  rw_q, rw_d;
  logic        wreg_q, wreg_d;
  logic        wmem_q, wmem_d;
  logic        rmem_q, rmem_d;

  logic [31:0] x_op;
  logic [31:0] y_op;
  logic [4:0]  sh;
  logic        is_mul;
  logic [31:0] res;

  assign x_op   = shift_ex ? {27'b0, imm_ex[10:6]} : a_ex;
  assign y_op   = aluimm_ex ? imm_ex : b_ex;
  assign sh     = x_op[4:0];
  assign is_mul = (op_ex == OP_MUL) && !jal_ex;

  // DONE is the one MUL cycle that is allowed to advance the pipeline
  assign stall_ex = is_mul && (state_q != S_DONE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_mul) begin
          state_d  = S_RUN;
          mcand_d  = a_ex;
          mplier_d = y_op;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res = '0;
    if (jal_ex) begin
      res = pc_ex;
    end else begin
      unique case (op_ex)
        OP_ADD:  res = x_op + y_op;
        OP_SUB:  res = x_op - y_op;
        OP_AND:  res = x_op & y_op;
        OP_OR:   res = x_op | y_op;
        OP_XOR:  res = x_op ^ y_op;
        OP_LUI:  res = {y_op[15:0], 16'b0};
        OP_SLL:  res = y_op << sh;
        OP_SRL:  res = y_op >> sh;
        OP_SRA:  res = 32'($signed(y_op) >>> sh);
        OP_SLT:  res = {31'b0, $signed(x_op) < $signed(y_op)};
        OP_SLTU: res = {31'b0, x_op < y_op};
        OP_MUL:  res = acc_q;
        default: res = '0;
      endcase
    end
  end

  always_comb begin
    alu_d  = res;
    b_d    = b_ex;
    rw_d   = rw_ex;
    wreg_d = wreg_ex;
    wmem_d = wmem_ex;
    rmem_d = rmem_ex;
    if (stall_ex) begin
      alu_d  = '0;
      b_d    = '0;
      rw_d   = '0;
      wreg_d = 1'b0;
      wmem_d = 1'b0;
      rmem_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      alu_q    <= '0;
      b_q      <= '0;
      rw_q     <= '0;
      wreg_q   <= 1'b0;
      wmem_q   <= 1'b0;
      rmem_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      alu_q    <= alu_d;
      b_q      <= b_d;
      rw_q     <= rw_d;
      wreg_q   <= wreg_d;
      wmem_q   <= wmem_d;
      rmem_q   <= rmem_d;
    end
  end

  assign alu_mem  = alu_q;
  assign b_mem    = b_q;
  assign rw_mem   = rw_q;
  assign wreg_mem = wreg_q;
  assign wmem_mem = wmem_q;
  assign rmem_mem = rmem_q;

endmodule
